sdp_mcif_rd_responder: RTL

Memory-side responder for the SDP read-request/response interface. It accepts SDP read requests, sequences one memory read per 64-bit beat on a simple synchronous SRAM read port, and returns the beats in order on the response channel. It enforces the requester's latency-FIFO credit scheme: beats are issued only against credits, and each sdp2mcif_rd_cdt_lat_fifo_pop pulse returns one credit. The block is used as the MCIF stand-in for SDP partition bring-up and FPGA builds.

---
 rtl/sdp_mcif_rd_responder_if.sv | 44 ++++
 rtl/sdp_mcif_rd_responder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sdp_mcif_rd_responder_if.sv
// rtl/sdp_mcif_rd_responder_if.sv - SDP read request/response, credit-return and SRAM read port bundle
// master = requester/SRAM environment, slave = the responder.
interface sdp_mcif_rd_responder_if #(
  parameter int AW     = 32,
  parameter int SIZE_W = 15,
  parameter int DW     = 64
);
  logic                 sdp2mcif_rd_req_valid;
  logic                 sdp2mcif_rd_req_ready;
  logic [AW+SIZE_W-1:0] sdp2mcif_rd_req_pd;
  logic                 sdp2mcif_rd_cdt_lat_fifo_pop;
  logic                 mcif2sdp_rd_rsp_valid;
  logic                 mcif2sdp_rd_rsp_ready;
  logic [DW:0]          mcif2sdp_rd_rsp_pd;
  logic                 mem_rd_en;
  logic [AW-1:0]        mem_rd_addr;
  logic [DW-1:0]        mem_rd_data;

  modport master (
    output sdp2mcif_rd_req_valid,
    output sdp2mcif_rd_req_pd,
    output sdp2mcif_rd_cdt_lat_fifo_pop,
    output mcif2sdp_rd_rsp_ready,
    output mem_rd_data,
    input  sdp2mcif_rd_req_ready,
    input  mcif2sdp_rd_rsp_valid,
    input  mcif2sdp_rd_rsp_pd,
    input  mem_rd_en,
    input  mem_rd_addr
  );

  modport slave (
    input  sdp2mcif_rd_req_valid,
    input  sdp2mcif_rd_req_pd,
    input  sdp2mcif_rd_cdt_lat_fifo_pop,
    input  mcif2sdp_rd_rsp_ready,
    input  mem_rd_data,
    output sdp2mcif_rd_req_ready,
    output mcif2sdp_rd_rsp_valid,
    output mcif2sdp_rd_rsp_pd,
    output mem_rd_en,
    output mem_rd_addr
  );
endinterface

// File: rtl/sdp_mcif_rd_responder.sv
// rtl/sdp_mcif_rd_responder.sv - credit-gated SDP read responder over a 1-cycle SRAM read port
// One SRAM read per 64-bit beat, returned in order through a small registered FIFO.
module sdp_mcif_rd_responder #(
  parameter int AW             = 32,
  parameter int SIZE_W         = 15,
  parameter int DW             = 64,
  parameter int LAT_FIFO_DEPTH = 8,
  parameter int BUF_DEPTH      = 3
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rst,
  sdp_mcif_rd_responder_if.slave        bus,
  output logic                          busy,
  output logic                          cdt_err
);

  localparam int CW  = $clog2(LAT_FIFO_DEPTH + 1);
  localparam int BCW = $clog2(BUF_DEPTH + 1);
  localparam int PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  localparam logic [CW-1:0] L_LAT       = CW'(LAT_FIFO_DEPTH);
  localparam logic [BCW:0]  L_BUF_DEPTH = (BCW + 1)'(BUF_DEPTH);
  localparam logic [PW-1:0] L_BUF_LAST  = PW'(BUF_DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_req_ready;
  logic [AW-1:0]       r_cur_addr;
  logic [SIZE_W-1:0]   r_remain;
  logic [CW-1:0]       r_credits;
  logic                r_cdt_err;
  logic                r_rd_inflight;
  logic [DW-1:0]       r_buf [BUF_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [BCW-1:0]      r_buf_count;

  logic                w_accept;
  logic                w_issue;
  logic                w_cdt_pop;
  logic                w_push;
  logic                w_pop_rsp;
  logic                w_buf_nonempty;
  logic [BCW:0]        w_occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == L_BUF_LAST) ? '0 : p + PW'(1);
  endfunction

  // Reads in flight count against the buffer so a returning beat always has a slot.
  assign w_occ          = {1'b0, r_buf_count} + {{BCW{1'b0}}, r_rd_inflight};
  assign w_accept       = bus.sdp2mcif_rd_req_valid && r_req_ready;
  assign w_issue        = (r_state == S_RUN) && (r_credits != '0) && (w_occ < L_BUF_DEPTH);
  assign w_cdt_pop      = bus.sdp2mcif_rd_cdt_lat_fifo_pop;
  assign w_buf_nonempty = (r_buf_count != '0);
  assign w_push         = r_rd_inflight;
  assign w_pop_rsp      = w_buf_nonempty && bus.mcif2sdp_rd_rsp_ready;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_cur_addr  <= '0;
      r_remain    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cur_addr  <= bus.sdp2mcif_rd_req_pd[AW-1:0];
            r_remain    <= bus.sdp2mcif_rd_req_pd[AW+SIZE_W-1:AW];
            r_state     <= S_RUN;
            r_req_ready <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_cur_addr <= r_cur_addr + AW'(8);
            if (r_remain == '0) begin
              r_state     <= S_IDLE;
              r_req_ready <= 1'b1;
            end else begin
              r_remain <= r_remain - SIZE_W'(1);
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  // A pop that would push credits past the latency-FIFO depth is dropped and flagged.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_credits <= L_LAT;
      r_cdt_err <= 1'b0;
    end else if (w_issue && !w_cdt_pop) begin
      r_credits <= r_credits - CW'(1);
    end else if (!w_issue && w_cdt_pop) begin
      if (r_credits == L_LAT) begin
        r_cdt_err <= 1'b1;
      end else begin
        r_credits <= r_credits + CW'(1);
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_rd_inflight <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_buf_count   <= '0;
    end else begin
      r_rd_inflight <= w_issue;
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop_rsp) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      unique case ({w_push, w_pop_rsp})
        2'b10:   r_buf_count <= r_buf_count + BCW'(1);
        2'b01:   r_buf_count <= r_buf_count - BCW'(1);
        default: r_buf_count <= r_buf_count;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge nvdla_core_clk) begin
    if (w_push) begin
      r_buf[r_wr_ptr] <= bus.mem_rd_data;
    end
  end

  assign bus.sdp2mcif_rd_req_ready = r_req_ready;
  assign bus.mem_rd_en             = w_issue;
  assign bus.mem_rd_addr           = w_issue ? r_cur_addr : '0;
  assign bus.mcif2sdp_rd_rsp_valid = w_buf_nonempty;
  assign bus.mcif2sdp_rd_rsp_pd    = {1'b1, r_buf[r_rd_ptr]};
  assign busy                      = (r_state == S_RUN) || r_rd_inflight || w_buf_nonempty;
  assign cdt_err                   = r_cdt_err;

endmodule
